// File: rtl/nonce_reporter_pkg.sv
// Shared miner definitions: nonce width, header byte and serializer states.
// ST_HDR only exists when NONCE_REPORTER_HEADER_EN is defined.
package nonce_reporter_pkg;

  localparam int         NONCE_W  = 64;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

`ifdef NONCE_REPORTER_HEADER_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/nonce_reporter_fifo.sv
// nonce_fifo: show-ahead FIFO with wrap-bit pointers, flush, and push-on-full
// allowed when a pop happens on the same edge.
module nonce_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign pop_data = mem[rd_ptr_q[AW-1:0]];

  // Flush discards everything, including a push or pop on the same edge.
  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & (~full | do_pop) & ~flush;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = flush ? wr_ptr_q : (do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/nonce_reporter.sv
// Buffers winning nonces and streams each one LSB-first as 8 bytes to a UART.
// Define NONCE_REPORTER_HEADER_EN to precede every word with a 0xA5 byte.
module nonce_reporter
  import nonce_reporter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [NONCE_W-1:0]     nonce_bus,
  input  logic                   nonce_bus_wr,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  state_e               state_q, state_d;
  logic [NONCE_W-1:0]   shreg_q, shreg_d;
  logic [2:0]           byte_cnt_q, byte_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NONCE_W-1:0]   fifo_head;

  nonce_fifo #(.WIDTH(NONCE_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (nonce_bus),
    .pop       (fifo_pop),
    .flush     (load),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A new job discards incoming nonces on the same cycle without flagging overflow.
  assign fifo_push = nonce_bus_wr & ~load;
  assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty & ~load;

  always_comb begin
    overflow_d = load ? 1'b0 : (overflow_q | (fifo_push & fifo_full & ~fifo_pop));
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          shreg_d    = fifo_head;
          byte_cnt_d = 3'd0;
`ifdef NONCE_REPORTER_HEADER_EN
          state_d    = ST_HDR;
`else
          state_d    = ST_SEND;
`endif
        end
      end
`ifdef NONCE_REPORTER_HEADER_EN
      ST_HDR: begin
        if (tx_ready) state_d = ST_SEND;
      end
`endif
      ST_SEND: begin
        if (tx_ready) begin
          shreg_d    = {8'h00, shreg_q[NONCE_W-1:8]};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      byte_cnt_q <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs decode registered state only, so they are stable until accepted.
  assign tx_valid = (state_q != ST_IDLE);
`ifdef NONCE_REPORTER_HEADER_EN
  assign tx_data  = (state_q == ST_HDR) ? HDR_BYTE : shreg_q[7:0];
`else
  assign tx_data  = shreg_q[7:0];
`endif
  assign overflow = overflow_q;

endmodule
